// File: rtl/calc_pkg.sv
// Shared opcodes, FSM state encoding and constants for the calculator stage.
// Pure declarations: no latency, no flow control.
package calc_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_LOAD = 2'b01,
        S_CALC = 2'b10,
        S_DONE = 2'b11
    } state_t;

    localparam logic [31:0] DIV0_RESULT = 32'hFFFF_FFFF;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchroniser, stable-level debouncer, rising-edge pulse.
// Latency: 2 sync cycles + DB_CYCLES stable samples; no backpressure (pulse is fire-and-forget).
module btn_debounce #(
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic rise_pulse
);

    localparam int CNT_W = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             db_level;
    logic [CNT_W-1:0] cnt;

    // cnt counts consecutive samples that disagree with the accepted level;
    // any agreeing sample restarts the run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            db_level   <= 1'b0;
            cnt        <= '0;
            rise_pulse <= 1'b0;
        end else begin
            sync1      <= btn_raw;
            sync2      <= sync1;
            rise_pulse <= 1'b0;
            if (sync2 == db_level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                db_level   <= sync2;
                rise_pulse <= sync2;
                cnt        <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/calc_core_hex.sv
// One add/sub/mul/div per debounced press; mul/div share one iterative shift register.
// Latency from start pulse: add/sub 3 cycles, mul/div 2+DATA_W; presses while busy are dropped.
// Divider present only when CALC_DIV_EN is defined; otherwise op 11 reports err with result 0.
module calc_core_hex
    import calc_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              btn_raw,
    input  logic [DATA_W-1:0] sw_a,
    input  logic [DATA_W-1:0] sw_b,
    input  logic [1:0]        sw_op,
    output logic [31:0]       cal_result,
    output logic              done,
    output logic              busy,
    output logic              err
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    state_t                state_q;
    state_t                state_d;
    logic                  start_pulse;
    logic [DATA_W-1:0]     a_q;
    logic [DATA_W-1:0]     b_q;
    logic [1:0]            op_q;
    logic [CNT_W-1:0]      cnt;
    logic [2*DATA_W-1:0]   acc;
    logic [2*DATA_W-1:0]   acc_nxt;
    logic [DATA_W:0]       mul_sum;
    logic [DATA_W:0]       add_sum;
    logic [DATA_W:0]       sub_diff;
    logic [31:0]           res_nxt;
    logic                  err_nxt;
    logic                  multi_op;
    logic                  calc_last;
`ifdef CALC_DIV_EN
    logic [DATA_W:0]       div_tmp;
    logic [DATA_W:0]       div_diff;
`endif

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_btn (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_raw    (btn_raw),
        .rise_pulse (start_pulse)
    );

`ifdef CALC_DIV_EN
    assign multi_op = (op_q == OP_MUL) || (op_q == OP_DIV);
`else
    assign multi_op = (op_q == OP_MUL);
`endif
    assign calc_last = !multi_op || (cnt == CNT_LAST);
    assign add_sum   = {1'b0, a_q} + {1'b0, b_q};
    assign sub_diff  = {1'b0, a_q} - {1'b0, b_q};

    // Mul: acc = {partial, multiplier}, shifted right each step.
    // Div: acc = {remainder, dividend/quotient}, shifted left each step.
    always_comb begin
        acc_nxt = acc;
        mul_sum = '0;
`ifdef CALC_DIV_EN
        div_tmp  = {acc[2*DATA_W-1:DATA_W], acc[DATA_W-1]};
        div_diff = div_tmp - {1'b0, b_q};
`endif
        case (op_q)
            OP_MUL: begin
                mul_sum = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, a_q} : '0);
                acc_nxt = {mul_sum, acc[DATA_W-1:1]};
            end
`ifdef CALC_DIV_EN
            OP_DIV: begin
                if (div_tmp >= {1'b0, b_q})
                    acc_nxt = {div_diff[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};
                else
                    acc_nxt = {div_tmp[DATA_W-1:0], acc[DATA_W-2:0], 1'b0};
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        res_nxt = '0;
        err_nxt = 1'b0;
        case (op_q)
            OP_ADD: res_nxt = 32'(add_sum);
            OP_SUB: res_nxt = {{(31-DATA_W){sub_diff[DATA_W]}}, sub_diff};
            OP_MUL: res_nxt = 32'(acc_nxt);
            default: begin
`ifdef CALC_DIV_EN
                if (b_q == '0) begin
                    res_nxt = DIV0_RESULT;
                    err_nxt = 1'b1;
                end else begin
                    res_nxt = (32'(acc_nxt[2*DATA_W-1:DATA_W]) << 16) | 32'(acc_nxt[DATA_W-1:0]);
                end
`else
                err_nxt = 1'b1;
`endif
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_pulse) state_d = S_LOAD;
            S_LOAD:  state_d = S_CALC;
            S_CALC:  if (calc_last) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= OP_ADD;
            cnt        <= '0;
            acc        <= '0;
            cal_result <= '0;
            err        <= 1'b0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    a_q  <= sw_a;
                    b_q  <= sw_b;
                    op_q <= sw_op;
                    cnt  <= '0;
                    err  <= 1'b0;
                    acc  <= (sw_op == OP_MUL) ? {{DATA_W{1'b0}}, sw_b} : {{DATA_W{1'b0}}, sw_a};
                end
                S_CALC: begin
                    acc <= acc_nxt;
                    cnt <= cnt + 1'b1;
                    // Result lands on the edge into DONE so it and done appear together.
                    if (calc_last) begin
                        cal_result <= res_nxt;
                        if (err_nxt) err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state_q == S_LOAD) || (state_q == S_CALC);
    assign done = (state_q == S_DONE);

endmodule
